// File: rtl/mload_pkg.sv
// Shared types and constants for the matrix loader front-end.
// Elements are packed row-major and MSB-first: element k occupies [MAT_W-1-ELEM_W*k -: ELEM_W].
package mload_pkg;

    localparam int ELEM_W = 8;
    localparam int MAX_N  = 5;
    localparam int MAT_W  = 200;
    localparam int ROW_W  = 40;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        CALC,
        DONE
    } state_e;

    // MSB bit position of element k inside the packed matrix (k*8 written as a 3-bit shift)
    function automatic logic [7:0] elem_msb(input logic [4:0] k);
        return 8'(MAT_W - 1) - {k, 3'b000};
    endfunction

endpackage

// File: rtl/mload_row_insert.sv
// Combinational row writer: drops the first n bytes of one row into the packed
// matrix at element offsets row_cnt*n + c, leaving every other element untouched.
module mload_row_insert
    import mload_pkg::*;
(
    input  logic [MAT_W-1:0] mat_in,
    input  logic [ROW_W-1:0] row_data,
    input  logic [2:0]       row_cnt,
    input  logic [2:0]       n,
    output logic [MAT_W-1:0] mat_next
);

    logic [ELEM_W-1:0] elems [MAX_N];
    logic [4:0]        k;

    // Split the row bus into its element bytes, element 0 in the top byte
    for (genvar g = 0; g < MAX_N; g++) begin : g_split
        assign elems[g] = row_data[ROW_W-1-ELEM_W*g -: ELEM_W];
    end

    // Overwrite the n elements of the current row; bytes c >= n are ignored
    always_comb begin
        mat_next = mat_in;
        k        = '0;
        for (int c = 0; c < MAX_N; c++) begin
            if (3'(c) < n) begin
                k = 5'(row_cnt) * 5'(n) + 5'(c);
                mat_next[elem_msb(k) -: ELEM_W] = elems[3'(c)];
            end
        end
    end

endmodule

// File: rtl/matrix_loader.sv
// Matrix loader: accepts an n x n signed-byte matrix one row per handshake,
// presents it packed on mat_out, waits SETTLE cycles for the external
// determinant unit and holds det/ovf under a valid/ready handshake.
// Optional feature macro: MLOAD_ABORT_EN adds the abort input, which cancels
// a load or settle phase and clears the matrix.
module matrix_loader
    import mload_pkg::*;
#(
    parameter int SETTLE = 1
)
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [2:0]         size,
    input  logic               row_valid,
    output logic               row_ready,
    input  logic [39:0]        row_data,
    output logic [199:0]       mat_out,
    output logic               mat_valid,
    input  logic signed [7:0]  det_in,
    input  logic               ovf_in,
    output logic               res_valid,
    input  logic               res_ready,
    output logic signed [7:0]  det_out,
    output logic               ovf_out,
    output logic               err,
`ifdef MLOAD_ABORT_EN
    input  logic               abort,
`endif
    output logic               busy
);

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE);

    state_e             state_q, state_d;
    logic [2:0]         n_q, n_d;
    logic [2:0]         row_cnt_q, row_cnt_d;
    logic [3:0]         settle_cnt_q, settle_cnt_d;
    logic [MAT_W-1:0]   mat_q, mat_d;
    logic signed [7:0]  det_q, det_d;
    logic               ovf_q, ovf_d;
    logic               err_q, err_d;
    logic               row_ready_q, row_ready_d;
    logic               mat_valid_q, mat_valid_d;
    logic               res_valid_q, res_valid_d;
    logic               busy_q, busy_d;
    logic [MAT_W-1:0]   mat_ins;

    mload_row_insert u_row_insert (
        .mat_in   (mat_q),
        .row_data (row_data),
        .row_cnt  (row_cnt_q),
        .n        (n_q),
        .mat_next (mat_ins)
    );

    // Next-state, datapath and registered-output decode for the load/settle/result FSM
    always_comb begin
        state_d      = state_q;
        n_d          = n_q;
        row_cnt_d    = row_cnt_q;
        settle_cnt_d = settle_cnt_q;
        mat_d        = mat_q;
        det_d        = det_q;
        ovf_d        = ovf_q;
        err_d        = err_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if ((size >= 3'd2) && (size <= 3'd5)) begin
                        state_d   = LOAD;
                        n_d       = size;
                        mat_d     = '0;
                        err_d     = 1'b0;
                        row_cnt_d = '0;
                    end else begin
                        // Illegal order: report straight away with a saturated-looking result
                        state_d = DONE;
                        err_d   = 1'b1;
                        det_d   = '0;
                        ovf_d   = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (row_valid) begin
                    mat_d = mat_ins;
                    if (row_cnt_q == n_q - 3'd1) begin
                        state_d      = CALC;
                        row_cnt_d    = '0;
                        settle_cnt_d = 4'd1;
                    end else begin
                        row_cnt_d = row_cnt_q + 3'd1;
                    end
                end
            end
            CALC: begin
                if (settle_cnt_q == SETTLE_LAST) begin
                    det_d        = det_in;
                    ovf_d        = ovf_in;
                    settle_cnt_d = '0;
                    state_d      = DONE;
                end else begin
                    settle_cnt_d = settle_cnt_q + 4'd1;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef MLOAD_ABORT_EN
        // Abort wins over a same-cycle row handshake or result capture
        if (abort && ((state_q == LOAD) || (state_q == CALC))) begin
            state_d      = IDLE;
            mat_d        = '0;
            row_cnt_d    = '0;
            settle_cnt_d = '0;
            det_d        = det_q;
            ovf_d        = ovf_q;
        end
`endif

        row_ready_d = (state_d == LOAD);
        mat_valid_d = (state_d == CALC) || (state_d == DONE);
        res_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    // State, counters, matrix and result registers; reset discards any load in progress
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            n_q          <= '0;
            row_cnt_q    <= '0;
            settle_cnt_q <= '0;
            mat_q        <= '0;
            det_q        <= '0;
            ovf_q        <= 1'b0;
            err_q        <= 1'b0;
            row_ready_q  <= 1'b0;
            mat_valid_q  <= 1'b0;
            res_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            n_q          <= n_d;
            row_cnt_q    <= row_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            mat_q        <= mat_d;
            det_q        <= det_d;
            ovf_q        <= ovf_d;
            err_q        <= err_d;
            row_ready_q  <= row_ready_d;
            mat_valid_q  <= mat_valid_d;
            res_valid_q  <= res_valid_d;
            busy_q       <= busy_d;
        end
    end

    assign row_ready = row_ready_q;
    assign mat_out   = mat_q;
    assign mat_valid = mat_valid_q;
    assign res_valid = res_valid_q;
    assign det_out   = det_q;
    assign ovf_out   = ovf_q;
    assign err       = err_q;
    assign busy      = busy_q;

endmodule
